mem_seq: RTL
============

# mem_seq

Memory-transaction sequencer for the CPU datapath. It owns the MAR load and both MDR enables: bus-side load into MDR and memory-side load into MDR. It drives the RAM read and write strobes. On a single read or write request from the control unit, it performs the full MAR → RAM → MDR sequence, waits for the memory's ready, and reports completion, or reports an error on timeout.

## Interface
- WIDTH, 32, datapath width (documentation only; no data passes through this block)
- TIMEOUT, 8, maximum ACCESS cycles waited for mem_ready before aborting (≥1)
- clk  in  1  rising-edge clock, sole clock domain
- clr_n  in  1  reset, synchronous, active-low
- rd_req  in  1  memory read request (level, sampled only in IDLE)
- wr_req  in  1  memory write request (level, sampled only in IDLE)
- mem_ready  in  1  RAM access complete; ignored outside ACCESS
- mar_in  out  1  load MAR from bus
- mdr_bus_en  out  1  MDR ← bus (MDR enable1)
- mdr_mem_en  out  1  MDR ← memory data (MDR enable2)
- mem_rd  out  1  RAM read strobe
- mem_wr  out  1  RAM write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (timeout or conflicting request)

## Operation
- States: IDLE, LOAD, ACCESS, CAPTURE, DONE, ERR.
  - One registered operation bit (RD/WR) is latched on leaving IDLE.
  - The TIMEOUT counter is $clog2(TIMEOUT+1) bits wide.
- IDLE: all outputs 0, counter 0.
  - rd_req only → LOAD with op=RD.
  - wr_req only → LOAD with op=WR.
  - Both high → ERR; no strobes, no MAR or MDR load.
  - Neither high → stay in IDLE.
- LOAD (1 cycle): mar_in=1. If op=WR, mdr_bus_en=1 in the same cycle. Counter cleared. → ACCESS.
- ACCESS: mem_rd=1 (RD) or mem_wr=1 (WR), held continuously. Counter increments each cycle.
  - If mem_ready=1 in an ACCESS cycle, that is the last ACCESS cycle: RD → CAPTURE, WR → DONE.
  - If the counter reaches TIMEOUT with no mem_ready, → ERR. The strobe lasts exactly TIMEOUT cycles.
  - If mem_ready and the timeout coincide in the same cycle, the ready wins (normal completion).
- CAPTURE (RD only, 1 cycle): mdr_mem_en=1. → DONE.
- DONE (1 cycle): done=1. → IDLE.
- ERR (1 cycle): err=1. → IDLE.
- Requests arriving while busy=1 are ignored; they are not queued. A request level still high in IDLE starts a new transaction, so back-to-back transactions are separated by one IDLE cycle.
- mdr_bus_en and mdr_mem_en are never high together. mem_rd and mem_wr are never high together.
- All outputs are Moore decodes of the state register and the op bit.

## Timing
- Cycle 0 is the IDLE cycle in which a request is sampled.
- Read, ready on the k-th ACCESS cycle:
  - LOAD at cycle 1.
  - ACCESS at cycles 2..k+1.
  - CAPTURE at cycle k+2.
  - done at cycle k+3.
- Write, ready on the k-th ACCESS cycle:
  - LOAD at cycle 1.
  - ACCESS at cycles 2..k+1.
  - done at cycle k+2.
- Minimum latency from sample to done is 4 cycles for a read and 3 cycles for a write.
- Timeout: ERR at cycle TIMEOUT+2.
- Reset:
  - clr_n=0 at any rising edge → state IDLE, op=RD, counter 0, all outputs 0 from the next cycle.
  - Reset takes effect mid-transaction with no completion pulse. The strobe drops immediately.

## Structure
- Shared package cpu_pkg holds:
  - mem_state_t enum (IDLE, LOAD, ACCESS, CAPTURE, DONE, ERR).
  - mem_op_t enum (RD, WR).
- Single module with a two-process FSM: a state/op/counter register and an output decode.
- No sub-module; the timeout counter stays inline.

## Test plan
- Read with TIMEOUT=4, mem_ready on the 2nd ACCESS cycle:
  - mar_in at cycle 1.
  - mem_rd at cycles 2–3.
  - mdr_mem_en at cycle 4.
  - done at cycle 5.
  - mdr_bus_en never high.
- Write with mem_ready held high:
  - mar_in and mdr_bus_en at cycle 1.
  - mem_wr at cycle 2 only.
  - done at cycle 3.
  - mdr_mem_en never high.
- Read with TIMEOUT=4, mem_ready never high:
  - mem_rd at cycles 2–5.
  - err at cycle 6.
  - done never high.
  - busy=0 at cycle 7.
- rd_req=wr_req=1 in IDLE:
  - err at cycle 1.
  - mar_in, mem_rd and mem_wr stay 0.
  - IDLE at cycle 2.
- clr_n=0 during the 2nd ACCESS cycle of a read:
  - Next cycle all outputs are 0 and busy=0, with no done or err.
  - A following write completes with done 3 cycles after its sample.
- rd_req held high, with wr_req pulsed during ACCESS:
  - The wr_req pulse is ignored.
  - After done, one IDLE cycle follows, then a new read starts (mar_in two cycles after done).

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: types shared across the CPU datapath control blocks.
//   mem_state_t : memory-transaction sequencer states
//   mem_op_t    : latched transaction direction (RD / WR)
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } mem_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_seq.sv
// mem_seq: memory-transaction sequencer.
// It accepts one read or write request from the control unit. It loads the MAR
// (and, for a write, the MDR from the bus). It then holds the RAM strobe until
// mem_ready arrives. For a read it captures memory data into the MDR, and it
// finishes with a one-cycle done pulse. If the access times out, or if both
// requests are raised together, it gives a one-cycle err pulse instead.
//
// Ports:
//   clk, clr_n          clock, synchronous active-low reset
//   rd_req, wr_req      request levels, sampled only in IDLE
//   mem_ready           RAM access complete, looked at only in ACCESS
//   mar_in              load MAR from bus
//   mdr_bus_en          MDR <- bus
//   mdr_mem_en          MDR <- memory
//   mem_rd, mem_wr      RAM strobes
//   busy, done, err     status
module mem_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic clr_n,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ready,
    output logic mar_in,
    output logic mdr_bus_en,
    output logic mdr_mem_en,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Elaboration-time guard; WIDTH only documents the datapath this block serves.
    if (TIMEOUT < 1 || WIDTH < 1) begin : g_bad_param
        $error("mem_seq: TIMEOUT and WIDTH must be >= 1");
    end

    mem_state_t    state, state_nxt;
    mem_op_t       op, op_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
            op    <= RD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, op latch and timeout counter
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (rd_req && wr_req) begin
                    state_nxt = ERR;
                end else if (rd_req) begin
                    state_nxt = LOAD;
                    op_nxt    = RD;
                end else if (wr_req) begin
                    state_nxt = LOAD;
                    op_nxt    = WR;
                end
            end
            LOAD: state_nxt = ACCESS;
            ACCESS: begin
                cnt_nxt = cnt + CW'(1);
                // Ready wins over a timeout landing in the same cycle.
                if (mem_ready)
                    state_nxt = (op == RD) ? CAPTURE : DONE;
                else if (cnt_nxt == CW'(TIMEOUT))
                    state_nxt = ERR;
            end
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode from state and op
    always_comb begin
        mar_in     = 1'b0;
        mdr_bus_en = 1'b0;
        mdr_mem_en = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            LOAD: begin
                mar_in     = 1'b1;
                mdr_bus_en = (op == WR);
            end
            ACCESS: begin
                mem_rd = (op == RD);
                mem_wr = (op == WR);
            end
            CAPTURE: mdr_mem_en = 1'b1;
            DONE:    done       = 1'b1;
            ERR:     err        = 1'b1;
            default: ;
        endcase
    end

endmodule
